esp_uart_rx: RTL and testbench
==============================

// Module: esp_uart_rx
//
// PURPOSE
//   Receives the ESP serial link arriving on esp_sig and decodes it into bytes.
//   The top level converts esp_sig_p/esp_sig_n to single-ended with an IBUFDS.
//   Sits directly downstream of that buffer, in the clk_100mhz domain produced by clkwiz_100mhz.
//   Decodes 8N1 asynchronous frames and presents each byte on a valid/ready stream for command logic and LED debug.
//
// PARAMETERS
//   CLKS_PER_BIT  868  clk_100mhz cycles per bit (100 MHz / 115200 baud); legal range >= 4
//   SYNC_STAGES   2    flops in the esp_sig metastability synchronizer; legal range >= 2
//   DATA_BITS     8    data bits per frame, sent LSB first
//
// PORTS
//   clk_100mhz   in   1          system clock, 100 MHz
//   sys_rst_n    in   1          synchronous, active-low reset
//   esp_sig      in   1          asynchronous serial line; idles high
//   m_data       out  DATA_BITS  received byte
//   m_valid      out  1          m_data holds an unconsumed byte
//   m_ready      in   1          consumer accepts the byte
//   framing_err  out  1          1-cycle pulse: stop bit sampled low
//   overrun      out  1          1-cycle pulse: new byte dropped because holding register was full
//   busy         out  1          high whenever the FSM is not in IDLE
//
// BEHAVIOUR
//   Reset (sys_rst_n low at a clk_100mhz edge):
//     - FSM goes to IDLE; counters clear.
//     - Every synchronizer flop is set to 1 (idle level).
//     - m_data=0, m_valid=0, framing_err=0, overrun=0, busy=0.
//     - Reset mid-frame abandons the partial byte; no pulse is emitted for it.
//   Synchronizer: esp_sig passes through SYNC_STAGES flops giving rx_s; all decoding uses rx_s only.
//   FSM states:
//     - IDLE:  on rx_s==0, clear bit_cnt, load clk_cnt=0 -> START.
//     - START: count to CLKS_PER_BIT/2-1 (mid start bit).
//         rx_s==1 there -> IDLE (glitch; no output).
//         Else clear clk_cnt -> DATA.
//     - DATA:  sample rx_s each time clk_cnt reaches CLKS_PER_BIT-1, then clear clk_cnt.
//         Shift the sample into shreg MSB, right-shift (LSB first).
//         After DATA_BITS samples -> STOP.
//     - STOP:  sample once at CLKS_PER_BIT-1.
//         rx_s==1 -> byte good.
//         rx_s==0 -> framing_err pulses 1 cycle, byte discarded.
//         Either way -> IDLE the next cycle, which re-arms for the next start edge.
//   Output latency: m_valid rises on the cycle after the good stop-bit sample.
//     That is SYNC_STAGES + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles (+/-1) after the start edge on esp_sig.
//   Handshake (one-entry holding register):
//     - The byte transfers on any cycle with m_valid && m_ready.
//     - m_data is stable while m_valid=1 and m_ready=0.
//     - A good byte completes while m_valid=0, or on the same cycle as a transfer: load m_data, m_valid stays/goes 1.
//     - A good byte completes while m_valid=1 and m_ready=0: the new byte is dropped, overrun pulses 1 cycle, and the held byte is kept.
//   Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is $clog2(DATA_BITS+1) bits. Neither counter wraps inside a state.
//   Line held low forever: the FSM cycles through the frame, signals framing_err, then re-enters START on the still-low line. framing_err therefore pulses once per frame time.
//
// STRUCTURE
//   Package esp_uart_pkg:
//     - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t
//     - localparam CLK_HZ = 100_000_000
//     - localparam BAUD_115200_CPB = 868
//   Sub-module bit_sync (parameter STAGES, RESET_VAL): generic single-bit synchronizer. Reused for btn/sw.
//   Everything else, i.e. FSM, counters, shift register and holding register, stays in esp_uart_rx.
//
// TESTING (bench: CLKS_PER_BIT=16, task drives esp_sig frames)
//   1. Frame 0xA5 with good stop, m_ready=1
//      -> one m_valid cycle with m_data=0xA5; no framing_err, no overrun.
//   2. Frame 0x3C with stop bit=0
//      -> framing_err one cycle, m_valid stays 0; a following 0x81 frame is received correctly.
//   3. Low pulse of 5 cycles on idle line
//      -> busy pulses high, then returns to IDLE; no m_valid, no framing_err.
//   4. m_ready=0, send 0x11 then 0x22 back-to-back
//      -> m_data=0x11 held, overrun pulses at end of 0x22.
//      Then m_ready=1 -> 0x11 transfers; next frame 0x33 is received normally.
//   5. Send 0x11, hold m_ready=0, complete 0x22 on the exact cycle m_ready=1
//      -> 0x11 transfers, m_data=0x22 with m_valid=1, no overrun.
//   6. sys_rst_n low during bit 4 of 0xF0, release, send 0x5A
//      -> no output for 0xF0, outputs zero during reset, then m_data=0x5A.

Source files
------------

// File: rtl/esp_uart_pkg.sv
// Shared types and constants for the ESP serial receive path.
// The default bit period is derived from the system clock and 115200 baud.
package esp_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int CLK_HZ          = 100_000_000;
    localparam int BAUD_115200_CPB = CLK_HZ / 115_200;

endpackage

// File: rtl/bit_sync.sv
// Generic single-bit metastability synchronizer with a configurable reset level.
// It is shared by the serial receiver and the button/switch inputs.
module bit_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/esp_uart_rx.sv
// 8N1 asynchronous receiver for the ESP link, with a one-entry valid/ready holding register.
// The receiver samples mid-bit: half a bit period after the start edge, then every full bit period.
module esp_uart_rx
    import esp_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = BAUD_115200_CPB,
    parameter int SYNC_STAGES  = 2,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_100mhz,
    input  logic                 sys_rst_n,
    input  logic                 esp_sig,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 byte_done;
    logic                 stop_bad;

    bit_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk_i  (clk_100mhz),
        .rst_ni (sys_rst_n),
        .d_i    (esp_sig),
        .q_o    (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (clk_cnt_q == HALF_END) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    byte_done = rx_s;
                    stop_bad  = !rx_s;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A finished byte may land in the same cycle the held byte is consumed.
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        ferr_d    = stop_bad;
        ovr_d     = 1'b0;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (byte_done) begin
            if (!m_valid_q || m_ready) begin
                m_data_d  = shreg_q;
                m_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_esp_uart_rx.sv
// Scoreboard bench for esp_uart_rx at 16 clocks per bit: stimulus pushes expected
// bytes and pulse tags, a negedge monitor pops and compares them.
module tb_esp_uart_rx;

    localparam int CPB = 16;

    logic       clk_100mhz = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       esp_sig    = 1'b1;
    logic       m_ready    = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int         n_vec     = 0;
    int         n_err     = 0;
    int         cur_test  = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] exp_bytes[$];
    int         exp_ferr[$];
    int         exp_ovr[$];

    always #5 clk_100mhz = ~clk_100mhz;

    esp_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (2),
        .DATA_BITS    (8)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .sys_rst_n   (sys_rst_n),
        .esp_sig     (esp_sig),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (test %0d): got %0h, expected %0h", name, cur_test, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s (test %0d): got %0h with nothing expected", name, cur_test, act);
    endtask

    // Called at a negedge; drives one full 10-bit frame, returning to idle high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        esp_sig = 1'b0;
        repeat (CPB) @(negedge clk_100mhz);
        for (int i = 0; i < 8; i++) begin
            esp_sig = b[i];
            repeat (CPB) @(negedge clk_100mhz);
        end
        esp_sig = stop_bit;
        repeat (CPB) @(negedge clk_100mhz);
        esp_sig = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_bytes.size() != 0; i++) @(negedge clk_100mhz);
        chk("bytes_drained", exp_bytes.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_data"}, m_data, 8'h00);
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_framing_err"}, framing_err, 1'b0);
        chk({tag, "_overrun"}, overrun, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Monitor: inputs change at negedge, so negedge+1 sees exactly what the next posedge uses.
    initial begin
        logic       hold;
        logic [7:0] held;
        logic [7:0] eb;
        int         id;
        hold = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk_100mhz);
            #1;
            if (busy) busy_seen = 1'b1;
            if (hold) chk("hold_stable", {m_valid, m_data}, {1'b1, held});
            if (m_valid && m_ready) begin
                if (exp_bytes.size() == 0) unexpected("spurious_byte", m_data);
                else begin
                    eb = exp_bytes.pop_front();
                    chk("m_data", m_data, eb);
                end
            end
            if (framing_err) begin
                if (exp_ferr.size() == 0) unexpected("spurious_framing_err", framing_err);
                else begin
                    id = exp_ferr.pop_front();
                    chk("framing_err_test", cur_test, id);
                end
            end
            if (overrun) begin
                if (exp_ovr.size() == 0) unexpected("spurious_overrun", overrun);
                else begin
                    id = exp_ovr.pop_front();
                    chk("overrun_test", cur_test, id);
                end
            end
            hold = m_valid && !m_ready;
            held = m_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk_100mhz);
        chk_outputs_zero("reset");
        sys_rst_n = 1'b1;
        repeat (4) @(negedge clk_100mhz);

        // 1: plain good frame
        cur_test = 1;
        exp_bytes.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk_100mhz);
        wait_drain();
        chk("t1_no_ferr_ovr", exp_ferr.size() + exp_ovr.size(), 0);

        // 2: bad stop bit, then a good frame after an idle gap
        cur_test = 2;
        exp_ferr.push_back(2);
        send_frame(8'h3C, 1'b0);
        repeat (2 * CPB) @(negedge clk_100mhz);
        exp_bytes.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (20) @(negedge clk_100mhz);
        wait_drain();
        chk("t2_ferr_seen", exp_ferr.size(), 0);

        // 3: short glitch on the idle line
        cur_test  = 3;
        busy_seen = 1'b0;
        esp_sig   = 1'b0;
        repeat (5) @(negedge clk_100mhz);
        esp_sig = 1'b1;
        repeat (40) @(negedge clk_100mhz);
        chk("t3_busy_seen", busy_seen, 1'b1);
        chk("t3_busy_idle", busy, 1'b0);

        // 4: overrun while the first byte is held
        cur_test = 4;
        m_ready  = 1'b0;
        exp_bytes.push_back(8'h11);
        exp_ovr.push_back(4);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (10) @(negedge clk_100mhz);
        chk("t4_held", {m_valid, m_data}, {1'b1, 8'h11});
        chk("t4_ovr_seen", exp_ovr.size(), 0);
        m_ready = 1'b1;
        exp_bytes.push_back(8'h33);
        send_frame(8'h33, 1'b1);
        repeat (20) @(negedge clk_100mhz);
        wait_drain();

        // 5: second byte completes on the very cycle the first is accepted
        cur_test = 5;
        m_ready  = 1'b0;
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (154) @(negedge clk_100mhz);
                m_ready = 1'b1;
            end
        join
        repeat (20) @(negedge clk_100mhz);
        wait_drain();
        chk("t5_no_ovr", exp_ovr.size(), 0);

        // 6: reset in the middle of bit 4 of 0xF0
        cur_test = 6;
        m_ready  = 1'b1;
        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * CPB + 8) @(negedge clk_100mhz);
                sys_rst_n = 1'b0;
                @(negedge clk_100mhz);
                chk_outputs_zero("midreset");
                repeat (2) @(negedge clk_100mhz);
                sys_rst_n = 1'b1;
            end
        join
        repeat (CPB) @(negedge clk_100mhz);
        exp_bytes.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk_100mhz);
        wait_drain();

        chk("end_ferr_queue", exp_ferr.size(), 0);
        chk("end_ovr_queue", exp_ovr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
